// File: rtl/cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// cic_integrator_chain
//
// Purpose:
//    Cascaded, pipelined CIC integrator section with time-division-multiplexed
//    channels. NUM_STAGES integrator stages each keep an independent
//    accumulator per channel. One sample per clock is accepted from any
//    channel in any order. Each stage performs exactly one read-modify-write
//    on its own accumulator array per cycle, so back-to-back samples on the
//    same channel need neither stalls nor forwarding. All arithmetic wraps
//    modulo 2^ACC_WIDTH; the downstream comb section cancels the wrap.
//
// Optional feature (compile-time macro):
//    CIC_INTEG_ROUND_EN - adds one output register stage that rounds half up
//                         instead of truncating, and saturates on positive
//                         overflow of the rounding addition. Latency becomes
//                         NUM_STAGES + 1.
//
// Parameters:
//    DATA_WIDTH_INP  input sample width (signed)
//    DATA_WIDTH_OUT  output sample width (signed)
//    ACC_WIDTH       accumulator width, >= both data widths
//    NUM_STAGES      integrator stages, 1..8
//    NUM_CHANNELS    independent channels, 1..16
//
// Ports:
//    clk            rising-edge clock
//    reset          synchronous, active-high reset
//    inp_samp_data  signed input sample
//    inp_samp_chan  channel index of the input sample
//    inp_samp_str   input sample valid
//    out_samp_data  signed output of the last stage (held while strobe low)
//    out_samp_chan  channel index of the output sample (held while strobe low)
//    out_samp_str   one-cycle pulse per output sample
// -----------------------------------------------------------------------------
module cic_integrator_chain #(
   parameter int  DATA_WIDTH_INP = 16,
   parameter int  DATA_WIDTH_OUT = 16,
   parameter int  ACC_WIDTH      = 40,
   parameter int  NUM_STAGES     = 4,
   parameter int  NUM_CHANNELS   = 2,
   localparam int CHAN_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
   input  logic        [CHAN_WIDTH-1:0]     inp_samp_chan,
   input  logic                             inp_samp_str,
   output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data,
   output logic        [CHAN_WIDTH-1:0]     out_samp_chan,
   output logic                             out_samp_str
);

   localparam int LAST = NUM_STAGES - 1;

   // Reject unsupported configurations at elaboration time.
   generate
      if ((ACC_WIDTH < DATA_WIDTH_INP) || (ACC_WIDTH < DATA_WIDTH_OUT)) begin : g_bad_acc_width
         $error("cic_integrator_chain: ACC_WIDTH must be >= DATA_WIDTH_INP and >= DATA_WIDTH_OUT");
      end
      if ((NUM_STAGES < 1) || (NUM_STAGES > 8)) begin : g_bad_num_stages
         $error("cic_integrator_chain: NUM_STAGES must be in 1..8");
      end
      if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > 16)) begin : g_bad_num_channels
         $error("cic_integrator_chain: NUM_CHANNELS must be in 1..16");
      end
   endgenerate

   // Per-stage, per-channel accumulators and the inter-stage pipeline.
   logic [ACC_WIDTH-1:0]  acc_q       [NUM_STAGES][NUM_CHANNELS];
   logic [ACC_WIDTH-1:0]  acc_d       [NUM_STAGES][NUM_CHANNELS];
   logic [ACC_WIDTH-1:0]  pipe_data_q [NUM_STAGES];
   logic [ACC_WIDTH-1:0]  pipe_data_d [NUM_STAGES];
   logic [CHAN_WIDTH-1:0] pipe_chan_q [NUM_STAGES];
   logic [CHAN_WIDTH-1:0] pipe_chan_d [NUM_STAGES];
   logic [NUM_STAGES-1:0] pipe_vld_q;
   logic [NUM_STAGES-1:0] pipe_vld_d;

   // What each stage sees this cycle: valid, channel, addend, and new sum.
   logic                  chan_ok_s;
   logic [NUM_STAGES-1:0] stg_vld_s;
   logic [CHAN_WIDTH-1:0] stg_chan_s [NUM_STAGES];
   logic [ACC_WIDTH-1:0]  stg_add_s  [NUM_STAGES];
   logic [ACC_WIDTH-1:0]  stg_sum_s  [NUM_STAGES];

   // Stage inputs: stage 0 takes the port sample, stage k the pipe(k-1) slot.
   always_comb begin
      // An out-of-range channel is dropped here so it becomes a bubble.
      chan_ok_s     = (32'(inp_samp_chan) < 32'(NUM_CHANNELS));
      stg_vld_s     = '0;
      stg_vld_s[0]  = inp_samp_str & chan_ok_s;
      stg_chan_s[0] = inp_samp_chan;
      stg_add_s[0]  = ACC_WIDTH'(inp_samp_data);
      for (int k = 1; k < NUM_STAGES; k++) begin
         stg_vld_s[k]  = pipe_vld_q[k-1];
         stg_chan_s[k] = pipe_chan_q[k-1];
         stg_add_s[k]  = pipe_data_q[k-1];
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
         stg_sum_s[k] = acc_q[k][stg_chan_s[k]] + stg_add_s[k];
      end
   end

   // Next state: one read-modify-write per stage; bubbles leave state alone.
   always_comb begin
      acc_d      = acc_q;
      pipe_vld_d = stg_vld_s;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (stg_vld_s[k]) begin
            acc_d[k][stg_chan_s[k]] = stg_sum_s[k];
            pipe_data_d[k]          = stg_sum_s[k];
            pipe_chan_d[k]          = stg_chan_s[k];
         end else begin
            pipe_data_d[k] = pipe_data_q[k];
            pipe_chan_d[k] = pipe_chan_q[k];
         end
      end
   end

   // Accumulator and pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               acc_q[k][c] <= '0;
            end
            pipe_data_q[k] <= '0;
            pipe_chan_q[k] <= '0;
         end
         pipe_vld_q <= '0;
      end else begin
         acc_q       <= acc_d;
         pipe_data_q <= pipe_data_d;
         pipe_chan_q <= pipe_chan_d;
         pipe_vld_q  <= pipe_vld_d;
      end
   end

`ifdef CIC_INTEG_ROUND_EN
   localparam int SHIFT    = ACC_WIDTH - DATA_WIDTH_OUT;
   localparam int HALF_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
   // Half an output LSB; zero when no bits are dropped so data passes through.
   localparam logic [ACC_WIDTH-1:0] HALF =
      (SHIFT > 0) ? (ACC_WIDTH'(1) << HALF_POS) : {ACC_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};

   // Round half up; a positive value that wraps negative on the +HALF saturates.
   function automatic logic [DATA_WIDTH_OUT-1:0] round_sat(input logic [ACC_WIDTH-1:0] acc);
      logic [ACC_WIDTH-1:0] sum;
      sum = acc + HALF;
      if (!acc[ACC_WIDTH-1] && sum[ACC_WIDTH-1]) begin
         round_sat = OUT_MAX;
      end else begin
         round_sat = sum[ACC_WIDTH-1 -: DATA_WIDTH_OUT];
      end
   endfunction

   logic [DATA_WIDTH_OUT-1:0] out_data_q;
   logic [DATA_WIDTH_OUT-1:0] out_data_d;
   logic [CHAN_WIDTH-1:0]     out_chan_q;
   logic [CHAN_WIDTH-1:0]     out_chan_d;
   logic                      out_vld_q;
   logic                      out_vld_d;

   // Output stage next state: rounded sample on a valid slot, otherwise hold.
   always_comb begin
      out_vld_d = pipe_vld_q[LAST];
      if (pipe_vld_q[LAST]) begin
         out_data_d = round_sat(pipe_data_q[LAST]);
         out_chan_d = pipe_chan_q[LAST];
      end else begin
         out_data_d = out_data_q;
         out_chan_d = out_chan_q;
      end
   end

   // Output register stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q <= '0;
         out_chan_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         out_data_q <= out_data_d;
         out_chan_q <= out_chan_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign out_samp_data = out_data_q;
   assign out_samp_chan = out_chan_q;
   assign out_samp_str  = out_vld_q;
`else
   // Plain truncation: the last pipeline register drives the outputs directly.
   // The pipe only loads on valid slots, so data and channel hold between strobes.
   assign out_samp_data = pipe_data_q[LAST][ACC_WIDTH-1 -: DATA_WIDTH_OUT];
   assign out_samp_chan = pipe_chan_q[LAST];
   assign out_samp_str  = pipe_vld_q[LAST];

   // The truncated low bits are intentionally dropped.
   logic unused_trunc_bits_s;
   assign unused_trunc_bits_s = ^pipe_data_q[LAST];
`endif

endmodule
